// File: rtl/mulred114689s_stream_if.sv
// Operand/result stream bus for the q = 114689 multiply-add front end.
interface mulred114689s_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_a;
  logic [16:0] in_b;
  logic [16:0] in_c;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_z;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_z
  );
endinterface

// File: rtl/mulred114689s.sv
// Streaming signed a*b + c front end feeding a fixed-latency mod-114689
// reducer; results are centred to [-57344, 57344] and buffered in a
// credit-protected FIFO so the enable-less reducer never has to stall.
module mulred114689s_stream #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mulred114689s_stream_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic signed [17:0] HALF = 18'sd57344;
  localparam logic signed [17:0] QV   = 18'sd114689;

  if (DEPTH < 6) begin : g_depth_check
    $error("mulred114689s_stream: DEPTH must be >= 6");
  end

  logic                  v1, v2, v3, v4, v5;
  logic signed [16:0]    a_r, b_r, c_r;
  logic signed [32:0]    in_z;
  logic signed [17:0]    red_z;
  logic signed [17:0]    z_c;
  logic [16:0]           z_w;
  logic [2:0]            inflight;
  logic                  accept, wr, rd;
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]         count, cnt_next;
  logic [16:0]           mem [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign inflight = 3'(v1) + 3'(v2) + 3'(v3) + 3'(v4) + 3'(v5);
  // Every accepted triple owns a FIFO slot; rst gating forces 0 during reset.
  assign bus.in_ready = rst && ((32'(count) + 32'(inflight)) < DEPTH);
  assign accept = bus.in_valid && bus.in_ready;
  assign wr     = v5;
  assign rd     = bus.out_valid && bus.out_ready;

  // Operand capture and product/sum stage, valid bits ride alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      v4   <= 1'b0;
      v5   <= 1'b0;
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      in_z <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a_r <= $signed(bus.in_a);
        b_r <= $signed(bus.in_b);
        c_r <= $signed(bus.in_c);
      end
      in_z <= 33'(34'(a_r) * 34'(b_r) + 34'(c_r));
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      v5 <= v4;
    end
  end

  modmul114689s u_red (
    .clk  (clk),
    .rst  (~rst),
    .inZ  (in_z),
    .outZ (red_z)
  );

  // Fold reducer output into the centred range with a single +/- q step.
  always_comb begin
    z_c = red_z;
    if (red_z > HALF) begin
      z_c = red_z - QV;
    end else if (red_z < -HALF) begin
      z_c = red_z + QV;
    end
    z_w = z_c[16:0];
  end

  // Next read pointer and occupancy after this cycle's read/write.
  always_comb begin
    rd_next  = rd ? ptr_inc(rd_ptr) : rd_ptr;
    cnt_next = count + CW'(wr) - CW'(rd);
  end

  // FIFO storage; content needs no reset because visibility is tracked by count.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= z_w;
    end
  end

  // Pointer/count bookkeeping and registered head; the head register bypasses
  // the array when the next head is the slot being written this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_z     <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr        <= rd_next;
      count         <= cnt_next;
      bus.out_valid <= (cnt_next != '0);
      if (cnt_next != '0) begin
        bus.out_z <= (wr && (rd_next == wr_ptr)) ? z_w : mem[rd_next];
      end
    end
  end
endmodule

// Signed mod-114689 reducer, fixed 3-cycle latency, no enable.
// Output is congruent to inZ and lies strictly inside (-114689, 114689).
module modmul114689s (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [32:0] inZ,
  output logic signed [17:0] outZ
);
  localparam logic signed [32:0] Q = 33'sd114689;

  logic signed [17:0] r1, r2;

  // Remainder in the first stage, then two balancing register stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1   <= '0;
      r2   <= '0;
      outZ <= '0;
    end else begin
      r1   <= 18'(inZ % Q);
      r2   <= r1;
      outZ <= r2;
    end
  end
endmodule
